mxv_cmd_loader: RTL and testbench

- Parametrised successor to the fixed-size MxV command/data-feed path.
- Consumes the byte stream from the UART receiver and parses framed commands of the form 0xFE, LEN, CMD, payload..., 0xEF.
- Routes matrix elements to one of MAX_N row-RAM channels and vector elements to the vector RAM.
- Owns the matrix size N, starts the MxV operation, and detects malformed frames.

---
 rtl/mxv_cmd_loader_pkg.sv | 26 ++
 rtl/mxv_rc_counter.sv | 37 +++
 rtl/mxv_cmd_loader.sv | 202 ++++++++++++++++++++
 tb/tb_mxv_cmd_loader.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mxv_cmd_loader_pkg.sv
// Shared framing constants and enums for the MxV command loader.
// Command codes and FSM states are reused by the operation unit.
package mxv_cmd_loader_pkg;

  localparam logic [7:0] SOF_BYTE  = 8'hFE;
  localparam logic [7:0] EOF_BYTE  = 8'hEF;
  localparam logic [7:0] FILL_BYTE = 8'hFF;

  typedef enum logic [7:0] {
    SET_SIZE = 8'h01,
    CLEAR    = 8'h02,
    START    = 8'h03,
    LOAD_VEC = 8'h04,
    LOAD_MAT = 8'h05
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_CMD,
    S_PAYLOAD,
    S_EOF,
    S_ERR
  } loader_state_t;

endpackage

// File: rtl/mxv_rc_counter.sv
// Row/column counter; the column wraps at i_limit-1 and carries into the row.
// Shared with the operation unit for its own matrix walk.
module mxv_rc_counter #(
  parameter int AW = 3,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_inc,
  input  logic [LW-1:0] i_limit,
  output logic [AW-1:0] o_row,
  output logic [AW-1:0] o_col
);

  logic w_last;

  assign w_last = (LW'(o_col) == i_limit - LW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_row <= '0;
      o_col <= '0;
    end else if (i_clr) begin
      o_row <= '0;
      o_col <= '0;
    end else if (i_inc) begin
      if (w_last) begin
        o_col <= '0;
        o_row <= o_row + AW'(1);
      end else begin
        o_col <= o_col + AW'(1);
      end
    end
  end

endmodule

// File: rtl/mxv_cmd_loader.sv
// Framed command parser feeding the MxV row/vector RAMs.
// Optional MXV_CMD_TIMEOUT_EN abandons frames idle for TIMEOUT_CYC cycles.
module mxv_cmd_loader
  import mxv_cmd_loader_pkg::*;
#(
  parameter int MAX_N       = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 100000,
  localparam int NW = $clog2(MAX_N + 1),
  localparam int AW = (MAX_N > 1) ? $clog2(MAX_N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              op_done,
  output logic [NW-1:0]     size_n,
  output logic [MAX_N-1:0]  row_we,
  output logic              vec_we,
  output logic [AW-1:0]     wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              start_op,
  output logic              clear_req,
  output logic              busy,
  output logic              frame_err
);

  loader_state_t r_state, w_next;
  logic [7:0]    r_len, r_rem;
  cmd_t          r_cmd;
  logic [NW-1:0] r_newn;
  logic          r_sup;
  logic [AW-1:0] w_row, w_col;
  logic [7:0]    w_pay;
  logic [15:0]   w_nn;
  logic          w_ok, w_to;
  logic          w_vec, w_mat, w_inc, w_rcclr, w_sup;
  logic          w_fire, w_clr, w_setn, w_newn;

  assign w_pay = r_len - 8'd2;
  assign w_nn  = 16'(size_n) * 16'(size_n);

  mxv_rc_counter #(.AW(AW), .LW(NW)) u_rc (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_rcclr),
    .i_inc   (w_inc),
    .i_limit (size_n),
    .o_row   (w_row),
    .o_col   (w_col)
  );

`ifdef MXV_CMD_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  logic [IW-1:0] r_idle;
  logic          w_open;

  assign w_open = (r_state != S_IDLE) && (r_state != S_ERR);
  assign w_to   = w_open && !rx_valid && (r_idle == IW'(TIMEOUT_CYC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_idle <= '0;
    else if (rx_valid || !w_open)
      r_idle <= '0;
    else if (r_idle != IW'(TIMEOUT_CYC))
      r_idle <= r_idle + IW'(1);
  end
`else
  assign w_to = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_ok    = 1'b0;
    w_vec   = 1'b0;
    w_mat   = 1'b0;
    w_inc   = 1'b0;
    w_rcclr = 1'b0;
    w_sup   = 1'b0;
    w_fire  = 1'b0;
    w_clr   = 1'b0;
    w_setn  = 1'b0;
    w_newn  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (rx_valid && rx_data == SOF_BYTE) w_next = S_LEN;
      end
      S_LEN: begin
        if (rx_valid) begin
          w_ok = (rx_data >= 8'd2) &&
                 (16'(rx_data) <= 16'(MAX_N * MAX_N + 2));
          w_next = w_ok ? S_CMD : S_ERR;
        end
      end
      S_CMD: begin
        if (rx_valid) begin
          w_rcclr = 1'b1;
          unique case (rx_data)
            SET_SIZE:      w_ok = (r_len == 8'd3);
            CLEAR, START:  w_ok = (r_len == 8'd2);
            LOAD_VEC:      w_ok = ({8'd0, w_pay} == 16'(size_n));
            LOAD_MAT:      w_ok = ({8'd0, w_pay} == w_nn);
            default:       w_ok = 1'b0;
          endcase
          if (!w_ok)               w_next = S_ERR;
          else if (r_rem == 8'd1)  w_next = S_EOF;
          else                     w_next = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (rx_valid) begin
          w_next = (r_rem == 8'd2) ? S_EOF : S_PAYLOAD;
          if (r_cmd == SET_SIZE) begin
            w_newn = 1'b1;
            if (rx_data == 8'd0 || 16'(rx_data) > 16'(MAX_N))
              w_next = S_ERR;
          end else begin
            w_inc = 1'b1;
            w_sup = busy;
            w_vec = !busy && (r_cmd == LOAD_VEC);
            w_mat = !busy && (r_cmd == LOAD_MAT);
          end
        end
      end
      S_EOF: begin
        if (rx_valid) begin
          w_next = S_IDLE;
          if (rx_data != EOF_BYTE)
            w_next = S_ERR;
          else if (r_cmd == SET_SIZE)
            w_setn = 1'b1;
          else if (r_cmd == CLEAR)
            w_clr = 1'b1;
          else if (r_cmd == START) begin
            if (busy) w_next = S_ERR;
            else      w_fire = 1'b1;
          end else if (r_sup)
            w_next = S_ERR;
        end
      end
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_to) w_next = S_ERR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len  <= '0;
      r_rem  <= '0;
      r_cmd  <= SET_SIZE;
      r_newn <= '0;
      r_sup  <= 1'b0;
    end else begin
      if (r_state == S_LEN && rx_valid) begin
        r_len <= rx_data;
        r_rem <= rx_data - 8'd1;
      end
      if (w_rcclr) begin
        r_cmd <= cmd_t'(rx_data);
        r_sup <= 1'b0;
      end
      if (r_state == S_PAYLOAD && rx_valid) r_rem <= r_rem - 8'd1;
      if (w_newn) r_newn <= NW'(rx_data);
      if (w_sup)  r_sup  <= 1'b1;
    end
  end

  // op_done landing on the start_op cycle belongs to the previous run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_n    <= NW'(MAX_N);
      row_we    <= '0;
      vec_we    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      start_op  <= 1'b0;
      clear_req <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      row_we    <= w_mat ? (MAX_N'(1) << w_row) : '0;
      vec_we    <= w_vec;
      start_op  <= w_fire;
      clear_req <= w_clr;
      busy      <= w_fire | (busy & ~(op_done & ~start_op));
      frame_err <= (w_next == S_ERR) && (r_state != S_ERR);
      if (w_setn) size_n <= r_newn;
      if (w_vec || w_mat) begin
        wr_addr <= w_col;
        wr_data <= DATA_W'(rx_data);
      end
    end
  end

endmodule

// File: tb/tb_mxv_cmd_loader.sv
// Directed bench for mxv_cmd_loader: framing, loads, start/busy, errors.
// Define MXV_CMD_TIMEOUT_EN to also exercise the stalled-frame timeout.
module tb_mxv_cmd_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       op_done;
  logic [3:0] size_n;
  logic [7:0] row_we;
  logic       vec_we;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       start_op, clear_req, busy, frame_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mxv_cmd_loader #(.MAX_N(8), .DATA_W(8), .TIMEOUT_CYC(50)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .op_done   (op_done),
    .size_n    (size_n),
    .row_we    (row_we),
    .vec_we    (vec_we),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start_op  (start_op),
    .clear_req (clear_req),
    .busy      (busy),
    .frame_err (frame_err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_size(input logic [7:0] n);
    send(8'hFE); send(8'h03); send(8'h01); send(n); send(8'hEF);
  endtask

  logic [7:0] mat_d [4] = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
  logic [7:0] mat_r [4] = '{8'h01, 8'h01, 8'h02, 8'h02};
  logic [2:0] mat_a [4] = '{3'd0, 3'd1, 3'd0, 3'd1};

  initial begin
    rst = 1'b1; rx_data = 8'hFF; rx_valid = 1'b0; op_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);
    chk("rst_size", size_n, 8);
    chk("rst_rowwe", row_we, 0);
    chk("rst_vecwe", vec_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_pulses", {start_op, clear_req}, 0);

    send(8'hFF);
    send(8'hFE); send(8'h03); send(8'h01); send(8'h04);
    chk("size_pre_eof", size_n, 8);
    send(8'hEF);
    chk("size_4", size_n, 4);
    chk("size_noerr", frame_err, 0);

    send(8'hFE); send(8'h06); send(8'h04);
    for (int k = 0; k < 4; k++) begin
      send(8'(k + 1));
      chk("vec_we", vec_we, 1);
      chk("vec_addr", wr_addr, k);
      chk("vec_data", wr_data, k + 1);
      chk("vec_rowwe", row_we, 0);
    end
    send(8'hEF);
    chk("vec_we_end", vec_we, 0);
    chk("vec_noerr", frame_err, 0);

    set_size(8'h02);
    chk("size_2", size_n, 2);
    send(8'hFE); send(8'h06); send(8'h05);
    for (int k = 0; k < 4; k++) begin
      send(mat_d[k]);
      chk("mat_rowwe", row_we, mat_r[k]);
      chk("mat_addr", wr_addr, mat_a[k]);
      chk("mat_data", wr_data, mat_d[k]);
      chk("mat_vecwe", vec_we, 0);
    end
    send(8'hEF);
    chk("mat_rowwe_end", row_we, 0);
    chk("mat_noerr", frame_err, 0);

    send(8'hFE); send(8'h02); send(8'h02); send(8'hEF);
    chk("clear_pulse", clear_req, 1);
    send(8'hFF);
    chk("clear_low", clear_req, 0);

    send(8'hFE); send(8'h02); send(8'h03);
    op_done = 1'b1;
    send(8'hEF);
    op_done = 1'b0;
    chk("start_pulse", start_op, 1);
    chk("busy_up", busy, 1);
    idle(1);
    chk("start_low", start_op, 0);
    chk("busy_hold", busy, 1);

    send(8'hFE); send(8'h02); send(8'h03); send(8'hEF);
    chk("start2_nopulse", start_op, 0);
    chk("start2_err", frame_err, 1);
    idle(1);
    chk("err_1cyc", frame_err, 0);

    send(8'hFE); send(8'h04); send(8'h04);
    send(8'h55);
    chk("busy_vec_sup", vec_we, 0);
    send(8'h66);
    chk("busy_vec_sup2", vec_we, 0);
    send(8'hEF);
    chk("busy_vec_err", frame_err, 1);

    op_done = 1'b1;
    idle(1);
    op_done = 1'b0;
    chk("busy_down", busy, 0);
    op_done = 1'b1;
    idle(1);
    op_done = 1'b0;
    chk("opdone_idle", busy, 0);

    send(8'hFE); send(8'h03); send(8'h01); send(8'h09);
    chk("size9_err", frame_err, 1);
    send(8'hEF);
    chk("size9_keep", size_n, 2);

    send(8'hFE); send(8'h02); send(8'h02); send(8'hAA);
    chk("eof_err", frame_err, 1);
    chk("eof_noclr", clear_req, 0);
    idle(1);

    send(8'hFE); send(8'h00);
    chk("len_err", frame_err, 1);
    idle(1);
    send(8'hFE); send(8'h42);
    chk("len_max_ok", frame_err, 0);
    send(8'h05);
    chk("matlen_err", frame_err, 1);
    idle(1);
    send(8'hFE); send(8'h02); send(8'h07);
    chk("cmd_err", frame_err, 1);
    idle(1);

    send(8'hFE); send(8'h04); send(8'h04);
    send(8'hFE);
    chk("fe_data_we", vec_we, 1);
    chk("fe_data", wr_data, 8'hFE);
    send(8'h11);
    chk("fe_addr1", wr_addr, 1);
    send(8'hEF);
    chk("fe_noerr", frame_err, 0);

`ifdef MXV_CMD_TIMEOUT_EN
    begin
      bit seen = 1'b0;
      send(8'hFE); send(8'h03);
      for (int i = 0; i < 60 && !seen; i++) begin
        idle(1);
        if (frame_err) seen = 1'b1;
      end
      chk("timeout_err", seen, 1);
      idle(2);
      set_size(8'h03);
      chk("timeout_recover", size_n, 3);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
